// File: rtl/beta_iter_shift_unit_if.sv
// Issue/writeback handshake bundle for the beta iterative shift unit.
// The master side (ALU issue logic) drives requests; the slave side is the shifter.
interface beta_iter_shift_unit_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned SHW = $clog2(XLEN);

  logic            start_i;
  logic [XLEN-1:0] operand_a_i;
  logic [SHW-1:0]  operand_b_i;
  logic [1:0]      mode_i;
  logic            kill_i;
  logic            ready_o;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, operand_a_i, operand_b_i, mode_i, kill_i,
    input  ready_o, busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, operand_a_i, operand_b_i, mode_i, kill_i,
    output ready_o, busy_o, valid_o, result_o
  );
endinterface

// File: rtl/beta_iter_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROR shifter: up to STEP bit positions per cycle,
// start/ready acceptance, one-cycle valid pulse, synchronous kill.
module beta_iter_shift_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  beta_iter_shift_unit_if.slave bus
);
  localparam int unsigned SHW   = $clog2(XLEN);
  localparam int unsigned SBITS = $clog2(STEP) + 1;
  localparam logic [SHW:0] STEP_W = (SHW + 1)'(STEP);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {M_SLL = 2'b00, M_SRL = 2'b01, M_SRA = 2'b10, M_ROR = 2'b11} mode_t;

  state_t            r_state;
  state_t            w_state_next;
  mode_t             r_mode;
  logic              r_sign;
  logic [SHW-1:0]    r_rem;
  logic [XLEN-1:0]   r_result;

  logic              w_ready;
  logic              w_accept;
  logic              w_fill;
  logic [SHW:0]      w_s;
  logic [SHW-1:0]    w_rem_next;
  logic [XLEN-1:0]   w_shifted;
  logic [2*XLEN-1:0] w_ext;

  assign w_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept = bus.start_i && w_ready && !bus.kill_i;
  assign w_fill   = (r_mode == M_SRA) && r_sign;

  // s = min(rem, STEP); rem never exceeds XLEN-1, so the subtraction fits SHW bits.
  assign w_s        = ({1'b0, r_rem} >= STEP_W) ? STEP_W : {1'b0, r_rem};
  assign w_rem_next = SHW'({1'b0, r_rem} - w_s);

  // Log-depth barrel of width STEP: one stage per bit of s.
  always_comb begin
    w_shifted = r_result;
    w_ext     = '0;
    for (int unsigned k = 0; k < SBITS; k++) begin
      if (w_s[k]) begin
        case (r_mode)
          M_SLL: w_shifted = w_shifted << (32'd1 << k);
          M_ROR: begin
            w_ext     = {w_shifted, w_shifted} >> (32'd1 << k);
            w_shifted = w_ext[XLEN-1:0];
          end
          default: begin
            w_ext     = {{XLEN{w_fill}}, w_shifted} >> (32'd1 << k);
            w_shifted = w_ext[XLEN-1:0];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.kill_i) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) w_state_next = (bus.operand_b_i != '0) ? S_SHIFT : S_DONE;
          else          w_state_next = S_IDLE;
        end
        S_SHIFT: if (w_rem_next == '0) w_state_next = S_DONE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_result <= '0;
      r_mode   <= M_SLL;
      r_sign   <= 1'b0;
      r_rem    <= '0;
    end else if (!bus.kill_i) begin
      if (w_accept) begin
        r_result <= bus.operand_a_i;
        r_mode   <= mode_t'(bus.mode_i);
        r_sign   <= bus.operand_a_i[XLEN-1];
        r_rem    <= bus.operand_b_i;
      end else if (r_state == S_SHIFT) begin
        r_result <= w_shifted;
        r_rem    <= w_rem_next;
      end
    end
  end

  assign bus.ready_o  = w_ready;
  assign bus.busy_o   = (r_state == S_SHIFT);
  assign bus.valid_o  = (r_state == S_DONE);
  assign bus.result_o = r_result;
endmodule

// File: tb/tb_beta_iter_shift_unit.sv
// Directed checks of the beta iterative shifter (STEP=4 and STEP=1 builds).
module tb_beta_iter_shift_unit;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  beta_iter_shift_unit_if #(.XLEN(32)) bus4 ();
  beta_iter_shift_unit_if #(.XLEN(32)) bus1 ();

  beta_iter_shift_unit #(.XLEN(32), .STEP(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));
  beta_iter_shift_unit #(.XLEN(32), .STEP(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE on the STEP=4 unit and check the full timeline.
  task automatic run_op(input string tag, input logic [1:0] mode, input logic [31:0] a,
                        input logic [4:0] n, input int k, input logic [31:0] exp);
    bus4.start_i = 1'b1; bus4.mode_i = mode; bus4.operand_a_i = a; bus4.operand_b_i = n;
    chk({tag, "_ready0"}, 32'(bus4.ready_o), 32'd1);
    tick();
    bus4.start_i = 1'b0; bus4.mode_i = ~mode; bus4.operand_a_i = ~a; bus4.operand_b_i = ~n;
    for (int c = 1; c <= k; c++) begin
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(bus4.busy_o), 32'd1);
      chk($sformatf("%s_novalid_c%0d", tag, c), 32'(bus4.valid_o), 32'd0);
      tick();
    end
    chk({tag, "_valid"}, 32'(bus4.valid_o), 32'd1);
    chk({tag, "_done_busy"}, 32'(bus4.busy_o), 32'd0);
    chk({tag, "_done_ready"}, 32'(bus4.ready_o), 32'd1);
    chk({tag, "_result"}, bus4.result_o, exp);
    tick();
    chk({tag, "_pulse"}, 32'(bus4.valid_o), 32'd0);
    chk({tag, "_hold"}, bus4.result_o, exp);
  endtask

  initial begin
    rst = 1'b1;
    bus4.start_i = 1'b0; bus4.operand_a_i = '0; bus4.operand_b_i = '0; bus4.mode_i = '0; bus4.kill_i = 1'b0;
    bus1.start_i = 1'b0; bus1.operand_a_i = '0; bus1.operand_b_i = '0; bus1.mode_i = '0; bus1.kill_i = 1'b0;
    tick();
    chk("rst_ready", 32'(bus4.ready_o), 32'd1);
    chk("rst_busy", 32'(bus4.busy_o), 32'd0);
    chk("rst_valid", 32'(bus4.valid_o), 32'd0);
    chk("rst_result", bus4.result_o, 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(bus4.ready_o), 32'd1);

    run_op("sll1x5", 2'b00, 32'h0000_0001, 5'd5, 2, 32'h0000_0020);
    run_op("sra31", 2'b10, 32'h8000_0000, 5'd31, 8, 32'hFFFF_FFFF);
    run_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 8, 32'h0000_0001);
    run_op("ror4", 2'b11, 32'h0000_00F1, 5'd4, 1, 32'h1000_000F);
    run_op("srl0", 2'b01, 32'hDEAD_BEEF, 5'd0, 0, 32'hDEAD_BEEF);
    run_op("sll_n7", 2'b00, 32'h8000_0001, 5'd7, 2, 32'h0000_0080);
    run_op("ror_n31", 2'b11, 32'h8000_0001, 5'd31, 8, 32'h0000_0003);

    // Handshake: start during busy is ignored; start in DONE is back-to-back.
    bus4.start_i = 1'b1; bus4.mode_i = 2'b00; bus4.operand_a_i = 32'h1; bus4.operand_b_i = 5'd8;
    tick();
    bus4.mode_i = 2'b01; bus4.operand_a_i = 32'h0000_FFFF; bus4.operand_b_i = 5'd3;
    chk("hs_busy_c1", 32'(bus4.busy_o), 32'd1);
    tick();
    chk("hs_busy_c2", 32'(bus4.busy_o), 32'd1);
    bus4.mode_i = 2'b01; bus4.operand_a_i = 32'h0000_0100; bus4.operand_b_i = 5'd8;
    tick();
    chk("hs_valid_c3", 32'(bus4.valid_o), 32'd1);
    chk("hs_result_c3", bus4.result_o, 32'h0000_0100);
    tick();
    bus4.start_i = 1'b0;
    chk("hs_pulse_c4", 32'(bus4.valid_o), 32'd0);
    chk("hs_b2b_busy_c4", 32'(bus4.busy_o), 32'd1);
    tick();
    chk("hs_b2b_busy_c5", 32'(bus4.busy_o), 32'd1);
    tick();
    chk("hs_b2b_valid_c6", 32'(bus4.valid_o), 32'd1);
    chk("hs_b2b_result", bus4.result_o, 32'h0000_0001);
    tick();
    chk("hs_b2b_pulse", 32'(bus4.valid_o), 32'd0);

    // Kill in cycle 2 of SRA by 20.
    bus4.start_i = 1'b1; bus4.mode_i = 2'b10; bus4.operand_a_i = 32'h8000_0000; bus4.operand_b_i = 5'd20;
    tick();
    bus4.start_i = 1'b0;
    tick();
    bus4.kill_i = 1'b1;
    chk("kill_pre_result", bus4.result_o, 32'hF800_0000);
    tick();
    bus4.kill_i = 1'b0;
    chk("kill_ready", 32'(bus4.ready_o), 32'd1);
    chk("kill_busy", 32'(bus4.busy_o), 32'd0);
    chk("kill_valid", 32'(bus4.valid_o), 32'd0);
    chk("kill_result", bus4.result_o, 32'hF800_0000);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("kill_novalid_%0d", c), 32'(bus4.valid_o), 32'd0);
    end

    // Same with reset in place of kill.
    bus4.start_i = 1'b1; bus4.mode_i = 2'b10; bus4.operand_a_i = 32'h8000_0000; bus4.operand_b_i = 5'd20;
    tick();
    bus4.start_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_ready", 32'(bus4.ready_o), 32'd1);
    chk("rstmid_busy", 32'(bus4.busy_o), 32'd0);
    chk("rstmid_valid", 32'(bus4.valid_o), 32'd0);
    chk("rstmid_result", bus4.result_o, 32'h0);
    tick();
    chk("rstmid_novalid", 32'(bus4.valid_o), 32'd0);

    // Kill with start in IDLE drops the request.
    bus4.start_i = 1'b1; bus4.kill_i = 1'b1; bus4.mode_i = 2'b00; bus4.operand_a_i = 32'h5; bus4.operand_b_i = 5'd0;
    tick();
    bus4.start_i = 1'b0; bus4.kill_i = 1'b0;
    chk("killstart_valid", 32'(bus4.valid_o), 32'd0);
    chk("killstart_busy", 32'(bus4.busy_o), 32'd0);
    chk("killstart_result", bus4.result_o, 32'h0);
    tick();
    chk("killstart_novalid", 32'(bus4.valid_o), 32'd0);

    // STEP=1 build: SRL 0x8000_0000 by 31.
    bus1.start_i = 1'b1; bus1.mode_i = 2'b01; bus1.operand_a_i = 32'h8000_0000; bus1.operand_b_i = 5'd31;
    tick();
    bus1.start_i = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      chk($sformatf("s1_busy_c%0d", c), 32'(bus1.busy_o), 32'd1);
      tick();
    end
    chk("s1_valid_c32", 32'(bus1.valid_o), 32'd1);
    chk("s1_result", bus1.result_o, 32'h0000_0001);
    tick();
    chk("s1_pulse", 32'(bus1.valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
